// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter FSM state encoding
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state)
// Contents:
//   UART_DATA_W      data bits per character
//   UART_IDLE        line level while no frame is on the wire
//   uart_tx_state_t  transmitter FSM states
package uart_pkg;

  localparam int   UART_DATA_W = 8;
  localparam logic UART_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte valid/ready handshake between register block and UART TX
// Signals:
//   i_data   byte offered by the master
//   i_valid  i_data is valid
//   o_ready  slave can accept; a transfer happens when i_valid & o_ready
// Modports: master (register block side), slave (transmitter side)
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] i_data;
  logic                   i_valid;
  logic                   o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with registered occupancy count
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2)
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (flushes contents)
//   i_push, i_data write one entry; ignored when full
//   i_pop          drop the head entry; ignored when empty
//   o_data         head entry (valid when !o_empty)
//   o_full/o_empty status decoded from the registered count
//   o_count        number of stored entries (one bit wider than pointers)
module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // The count never exceeds DEPTH, a power of two, so its MSB alone marks full.
  assign o_full  = count_q[AW];
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries covered by the count are ever read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: FIFO-buffered, LSB-first, baud-tick driven
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data bits)
// Parameters: FIFO_DEPTH (power of two, >= 2), STOP_BITS (1 or 2)
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_baud_tick  one-cycle strobe per bit period
//   bus          slave side of the byte handshake (i_data/i_valid/o_ready)
//   o_tx         serial line, idle high
//   o_busy       frame in progress or bytes queued (registered)
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_baud_tick,
  uart_tx_if.slave    bus,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int   AW        = $clog2(FIFO_DEPTH);
  // stopcnt value on the last stop-bit tick
  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_tx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   stopcnt_q, stopcnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   push, pop, take;
  logic                   fifo_full, fifo_empty;
  logic [AW:0]            fifo_count;
  logic [UART_DATA_W-1:0] fifo_data;

  assign bus.o_ready = !fifo_full;
  assign push        = bus.i_valid && !fifo_full;
  assign o_tx        = tx_q;
  assign o_busy      = busy_q;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (bus.i_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      tx_q      <= UART_IDLE;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    tx_d      = tx_q;
    take      = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (i_baud_tick) begin
      case (state_q)
        S_IDLE: begin
          tx_d = UART_IDLE;
          take = !fifo_empty;
        end
        S_START: begin
          tx_d     = sh_q[0];
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
        S_DATA: begin
          if (bitcnt_q != 3'd7) begin
            sh_d     = sh_q >> 1;
            tx_d     = sh_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d      = parity_q;
            state_d   = S_PARITY;
`else
            tx_d      = UART_IDLE;
            stopcnt_d = 1'b0;
            state_d   = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx_d      = UART_IDLE;
          stopcnt_d = 1'b0;
          state_d   = S_STOP;
        end
`endif
        S_STOP: begin
          if (stopcnt_q == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting.
            take    = !fifo_empty;
            tx_d    = UART_IDLE;
            state_d = S_IDLE;
          end else begin
            stopcnt_d = 1'b1;
            tx_d      = UART_IDLE;
          end
        end
        default: begin
          tx_d    = UART_IDLE;
          state_d = S_IDLE;
        end
      endcase
    end

    if (take) begin
      pop     = 1'b1;
      sh_d    = fifo_data;
      tx_d    = 1'b0;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      // Parity is latched at load time because the shift register is consumed.
      parity_d = ^fifo_data;
`endif
    end

    // Busy if a frame continues or the FIFO holds anything after this cycle.
    busy_d = (state_d != S_IDLE) || push || (fifo_count > {{AW{1'b0}}, pop});
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (STOP_BITS=1 and STOP_BITS=2 instances)
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;   // even parity of data, worked out by hand
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, tick;
  logic tx1, busy1, tx2, busy2;

  uart_tx_if bus1 ();
  uart_tx_if bus2 ();

  uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .i_clk       (clk),
    .i_rst       (rst1),
    .i_baud_tick (tick),
    .bus         (bus1),
    .o_tx        (tx1),
    .o_busy      (busy1)
  );

  uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .i_clk       (clk),
    .i_rst       (rst2),
    .i_baud_tick (tick),
    .bus         (bus2),
    .o_tx        (tx2),
    .o_busy      (busy2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cap_q[$];
  bit   exp_q[$];
  vec_t vecs[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_stream(string name);
    string a, e;
    bit    ok;
    a  = "";
    e  = "";
    ok = (cap_q.size() == exp_q.size());
    foreach (cap_q[i]) a = {a, cap_q[i] ? "1" : "0"};
    foreach (exp_q[i]) begin
      e = {e, exp_q[i] ? "1" : "0"};
      if (i < cap_q.size() && cap_q[i] != exp_q[i]) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: line per tick %s, required %s", name, a, e);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  function automatic int frame_ticks(int sel);
    return 1 + 8 + P + sel;
  endfunction

  // One baud tick every 4 clocks; the line is sampled just after the tick edge.
  task automatic ticks(int sel, int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      cap_q.push_back(sel == 2 ? tx2 : tx1);
      tick = 1'b0;
      repeat (3) cyc();
    end
  endtask

  task automatic push(int sel, logic [7:0] d);
    check("ready_before_push", sel == 2 ? bus2.o_ready : bus1.o_ready, 1);
    if (sel == 2) begin
      bus2.i_data  = d;
      bus2.i_valid = 1'b1;
    end else begin
      bus1.i_data  = d;
      bus1.i_valid = 1'b1;
    end
    cyc();
    // Scramble the data lines afterwards: the queued byte must not follow them.
    bus1.i_valid = 1'b0;
    bus2.i_valid = 1'b0;
    bus1.i_data  = ~d;
    bus2.i_data  = ~d;
  endtask

  task automatic add_frame(logic [7:0] d, logic par, int stops);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (P == 1) exp_q.push_back(par);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'h01, 1'b1};

    rst1 = 1'b1;
    rst2 = 1'b1;
    tick = 1'b0;
    bus1.i_valid = 1'b0;
    bus1.i_data  = 8'h00;
    bus2.i_valid = 1'b0;
    bus2.i_data  = 8'h00;
    repeat (3) cyc();
    rst1 = 1'b0;
    rst2 = 1'b0;
    cyc();

    check("reset_tx1", tx1, 1);
    check("reset_busy1", busy1, 0);
    check("reset_ready1", bus1.o_ready, 1);
    check("reset_tx2", tx2, 1);
    check("reset_busy2", busy2, 0);
    check("reset_ready2", bus2.o_ready, 1);

    // Ticks with nothing queued are ignored.
    ticks(1, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
    check_stream("idle_ticks");
    check("idle_busy", busy1, 0);

    // Single frames on both stop-bit configurations.
    for (int sel = 1; sel <= 2; sel++) begin
      for (int v = 0; v < 6; v++) begin
        push(sel, vecs[v].data);
        check("busy_after_push", sel == 2 ? busy2 : busy1, 1);
        ticks(sel, frame_ticks(sel));
        check("busy_in_last_stop", sel == 2 ? busy2 : busy1, 1);
        ticks(sel, 1);
        check("busy_after_frame", sel == 2 ? busy2 : busy1, 0);
        add_frame(vecs[v].data, vecs[v].par, sel);
        exp_q.push_back(1'b1);
        check_stream($sformatf("frame_s%0d_%02h", sel, vecs[v].data));
      end
    end

    // A tick in the same cycle as the push must not start the frame.
    bus1.i_data  = 8'h5A;
    bus1.i_valid = 1'b1;
    tick = 1'b1;
    cyc();
    bus1.i_valid = 1'b0;
    tick = 1'b0;
    check("tick_with_push_no_start", tx1, 1);
    check("tick_with_push_busy", busy1, 1);
    repeat (3) cyc();
    ticks(1, frame_ticks(1) + 1);
    add_frame(8'h5A, 1'b0, 1);
    exp_q.push_back(1'b1);
    check_stream("tick_with_push_frame");

    // Back-to-back frames with no idle bit between them.
    push(1, 8'h00);
    push(1, 8'hFF);
    push(1, 8'h55);
    ticks(1, 3 * frame_ticks(1) + 1);
    add_frame(8'h00, 1'b0, 1);
    add_frame(8'hFF, 1'b0, 1);
    add_frame(8'h55, 1'b0, 1);
    exp_q.push_back(1'b1);
    check_stream("back_to_back");
    check("b2b_busy_end", busy1, 0);

    // FIFO full: hold valid with no ticks.
    bus1.i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus1.i_data = 8'h10 + 8'(k);
      check($sformatf("fill_ready_%0d", k), bus1.o_ready, (k < 4) ? 1 : 0);
      cyc();
    end
    bus1.i_valid = 1'b0;
    check("ready_when_full", bus1.o_ready, 0);
    ticks(1, 1);
    check("ready_after_pop", bus1.o_ready, 1);
    push(1, 8'h14);
    ticks(1, 5 * frame_ticks(1));
    add_frame(8'h10, 1'b1, 1);
    add_frame(8'h11, 1'b0, 1);
    add_frame(8'h12, 1'b0, 1);
    add_frame(8'h13, 1'b1, 1);
    add_frame(8'h14, 1'b0, 1);
    exp_q.push_back(1'b1);
    check_stream("fifo_order");
    check("fifo_busy_end", busy1, 0);

    // Back-to-back with two stop bits.
    push(2, 8'h3C);
    push(2, 8'h81);
    ticks(2, 2 * frame_ticks(2) + 1);
    add_frame(8'h3C, 1'b0, 2);
    add_frame(8'h81, 1'b0, 2);
    exp_q.push_back(1'b1);
    check_stream("stop2_back_to_back");

    // Reset in the middle of DATA with a second byte queued.
    push(1, 8'hC3);
    push(1, 8'h3C);
    ticks(1, 5);
    check("pre_reset_tx_low", tx1, 0);
    cap_q.delete();
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    check("mid_reset_tx", tx1, 1);
    check("mid_reset_busy", busy1, 0);
    check("mid_reset_ready", bus1.o_ready, 1);
    ticks(1, 2 * frame_ticks(1) + 2);
    for (int i = 0; i < 2 * frame_ticks(1) + 2; i++) exp_q.push_back(1'b1);
    check_stream("after_reset_silent");
    check("after_reset_busy", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
